gcd_share_arbiter: RTL and testbench

- Round-robin scheduler that shares one subtractive GCD engine (datapath + controller pair) between N requesters.
- Grants one requester at a time and drives the engine's start/serial-operand load sequence. Waits for engine done, then returns the result to the granted requester.
- Zero operands are resolved locally without the engine (the subtractive loop never terminates on 0). A watchdog guards against a hung engine.

---
 rtl/gcd_share_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_gcd_share_arbiter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_share_arbiter.sv
// Round-robin front end that shares one subtractive GCD engine between N
// requesters. Zero operands are answered locally because the subtractive
// loop never terminates on 0; a watchdog bounds the wait for a hung engine.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | no transaction; pick next requester round-robin from ptr
// S_START  | one-cycle start pulse to the engine
// S_LOAD_A | operand A on the serial bus
// S_LOAD_B | operand B on the serial bus, watchdog cleared
// S_WAIT   | waiting for eng_done, watchdog counting
// S_RESP   | one-cycle response to the granted requester, advance ptr
module gcd_share_arbiter #(
    parameter int N       = 4,
    parameter int W       = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    output logic [N-1:0]   resp_valid,
    output logic [W-1:0]   resp_gcd,
    output logic           resp_err,
    output logic           busy,
    output logic           eng_start,
    output logic [W-1:0]   eng_data,
    input  logic           eng_done,
    input  logic [W-1:0]   eng_result
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_LOAD_A,
        S_LOAD_B,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] ptr;
    logic [IW-1:0] idx;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  result_q;
    logic          err_q;
    logic [CW-1:0] wdog;

    logic          grant_vld;
    logic [IW-1:0] grant_idx;
    logic [W-1:0]  grant_a;
    logic [W-1:0]  grant_b;
    logic          grant_bypass;
    logic          wdog_expired;

    // Round-robin search: first requester at or above ptr, wrapping past N-1.
    always_comb begin
        logic [IW:0] cand;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!grant_vld && req[cand[IW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[IW-1:0];
            end
        end
    end

    // Operand mux for the winning requester, plus the zero-operand bypass test.
    always_comb begin
        grant_a = '0;
        grant_b = '0;
        for (int k = 0; k < N; k++) begin
            if (grant_idx == IW'(k)) begin
                grant_a = req_a[k*W +: W];
                grant_b = req_b[k*W +: W];
            end
        end
        grant_bypass = (grant_a == '0) || (grant_b == '0);
    end

    assign wdog_expired = (wdog == CW'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; eng_done wins over a watchdog expiry in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (grant_vld) begin
                    state_nxt = grant_bypass ? S_RESP : S_START;
                end
            end
            S_START:  state_nxt = S_LOAD_A;
            S_LOAD_A: state_nxt = S_LOAD_B;
            S_LOAD_B: state_nxt = S_WAIT;
            S_WAIT: begin
                if (eng_done || wdog_expired) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Transaction registers: grant capture, result/error capture, watchdog, RR pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            idx      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            wdog     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_vld) begin
                        idx      <= grant_idx;
                        a_q      <= grant_a;
                        b_q      <= grant_b;
                        // gcd(x,0)=x and gcd(0,0)=0; overwritten on the engine path
                        result_q <= grant_a | grant_b;
                        err_q    <= 1'b0;
                    end
                end
                S_LOAD_B: begin
                    wdog <= '0;
                end
                S_WAIT: begin
                    wdog <= wdog + CW'(1);
                    if (eng_done) begin
                        result_q <= eng_result;
                        err_q    <= 1'b0;
                    end else if (wdog_expired) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                    end
                end
                S_RESP: begin
                    ptr <= (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        resp_valid = '0;
        resp_gcd   = '0;
        resp_err   = 1'b0;
        busy       = (state != S_IDLE);
        eng_start  = 1'b0;
        eng_data   = '0;
        case (state)
            S_START:  eng_start = 1'b1;
            S_LOAD_A: eng_data  = a_q;
            S_LOAD_B: eng_data  = b_q;
            S_RESP: begin
                for (int k = 0; k < N; k++) begin
                    resp_valid[k] = (idx == IW'(k));
                end
                resp_gcd = result_q;
                resp_err = err_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_gcd_share_arbiter.sv
// Bench for gcd_share_arbiter: requester and engine models driven on the
// falling edge, a transaction-level round-robin/GCD reference model, and
// timing expectations derived from the documented handshake latencies.
module tb_gcd_share_arbiter;

    localparam int N        = 4;
    localparam int W        = 16;
    localparam int TO       = 16;
    localparam int MAXJ     = 8;
    localparam int HANG_LAT = 100000;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   resp_valid;
    logic [W-1:0]   resp_gcd;
    logic           resp_err;
    logic           busy;
    logic           eng_start;
    logic [W-1:0]   eng_data;
    logic           eng_done = 1'b0;
    logic [W-1:0]   eng_result = '0;

    always #5 clk = ~clk;

    gcd_share_arbiter #(.N(N), .W(W), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_gcd   (resp_gcd),
        .resp_err   (resp_err),
        .busy       (busy),
        .eng_start  (eng_start),
        .eng_data   (eng_data),
        .eng_done   (eng_done),
        .eng_result (eng_result)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Euclid by remainder; also covers the zero-operand cases.
    function automatic int ref_gcd(input int a, input int b);
        int x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // ---------------- requester side ----------------
    logic [W-1:0] ja [N][MAXJ];
    logic [W-1:0] jb [N][MAXJ];
    int  jn   [N];
    int  jpos [N];
    bit  pend [N];

    int log_idx[$];
    int log_gcd[$];
    int log_err[$];
    int log_cyc[$];
    int rise_q[$];
    int gap_q[$];
    int low_run   = 0;
    logic busy_d  = 1'b0;
    int multi_hot = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_d  = 1'b0;
            low_run = 0;
        end else begin
            if (busy && !busy_d) begin
                rise_q.push_back(cyc);
                gap_q.push_back(low_run);
            end
            low_run = busy ? 0 : low_run + 1;
            busy_d  = busy;
            if ($countones(resp_valid) > 1) multi_hot++;
            for (int i = 0; i < N; i++) begin
                if (resp_valid[i]) begin
                    log_idx.push_back(i);
                    log_gcd.push_back(int'(resp_gcd));
                    log_err.push_back(int'(resp_err));
                    log_cyc.push_back(cyc);
                    req[i]  = 1'b0;
                    pend[i] = 1'b0;
                    jpos[i]++;
                end else if (!pend[i] && jpos[i] < jn[i]) begin
                    req[i]            = 1'b1;
                    req_a[i*W +: W]   = ja[i][jpos[i]];
                    req_b[i*W +: W]   = jb[i][jpos[i]];
                    pend[i]           = 1'b1;
                end
            end
        end
    end

    // ---------------- engine side ----------------
    int eng_phase     = 0;
    int eng_cnt       = 0;
    int eng_lat_cur   = 0;
    int eng_fixed_lat = 5;
    bit eng_rand      = 1'b0;
    bit eng_hang      = 1'b0;
    int eng_start_cycles = 0;
    int start_q[$];
    int lat_q[$];
    int cap_a[$];
    int cap_b[$];
    logic [W-1:0] ea = '0;
    logic [W-1:0] eb = '0;

    always @(negedge clk) begin
        eng_done   = 1'b0;
        eng_result = W'($urandom);
        if (!rst_n) begin
            eng_phase = 0;
        end else if (eng_start) begin
            eng_start_cycles++;
            eng_phase = 1;
            start_q.push_back(cyc);
            eng_lat_cur = eng_hang ? HANG_LAT :
                          (eng_rand ? int'($urandom_range(1, 18)) : eng_fixed_lat);
            lat_q.push_back(eng_lat_cur);
        end else begin
            case (eng_phase)
                1: begin
                    ea = eng_data;
                    eng_phase = 2;
                end
                2: begin
                    eb = eng_data;
                    cap_a.push_back(int'(ea));
                    cap_b.push_back(int'(eb));
                    eng_cnt   = 0;
                    eng_phase = 3;
                end
                3: begin
                    eng_cnt++;
                    if (eng_cnt == eng_lat_cur) begin
                        eng_done   = 1'b1;
                        eng_result = W'(ref_gcd(int'(ea), int'(eb)));
                        eng_phase  = 0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------- reference model and batch runner ----------------
    int model_ptr = 0;

    task automatic clear_jobs();
        for (int i = 0; i < N; i++) begin
            jn[i]   = 0;
            jpos[i] = 0;
            pend[i] = 1'b0;
            req[i]  = 1'b0;
        end
    endtask

    task automatic add_job(input int i, input int a, input int b);
        ja[i][jn[i]] = W'(a);
        jb[i][jn[i]] = W'(b);
        jn[i]++;
    endtask

    task automatic run_batch(input string name, input int total, input bit scramble);
        int lb, rb, ebase, sb, budget, eidx, pick, lat, exp_g, exp_e, wait_c;
        int mpos [N];
        logic [W-1:0] a, b;
        bit scr;
        lb    = log_idx.size();
        rb    = rise_q.size();
        ebase = start_q.size();
        sb    = eng_start_cycles;
        scr   = 1'b0;
        budget = 60 * total + 40;
        while (log_idx.size() < lb + total && budget > 0) begin
            @(negedge clk);
            budget--;
            if (scramble && !scr && start_q.size() > ebase) begin
                for (int i = 0; i < N; i++) begin
                    if (pend[i]) begin
                        req[i]          = 1'b0;
                        req_a[i*W +: W] = '1;
                        req_b[i*W +: W] = W'(1);
                    end
                end
                scr = 1'b1;
            end
        end
        repeat (3) @(negedge clk);
        check_eq({name, "_count"}, log_idx.size() - lb, total);

        eidx = ebase;
        for (int i = 0; i < N; i++) mpos[i] = 0;
        for (int k = 0; k < total; k++) begin
            pick = -1;
            for (int s = 0; s < N; s++) begin
                if (pick < 0 && mpos[(model_ptr + s) % N] < jn[(model_ptr + s) % N])
                    pick = (model_ptr + s) % N;
            end
            if (pick < 0) break;
            a = ja[pick][mpos[pick]];
            b = jb[pick][mpos[pick]];
            mpos[pick]++;
            model_ptr = (pick + 1) % N;
            if (a == '0 || b == '0) begin
                exp_e = 0;
                exp_g = ref_gcd(int'(a), int'(b));
                if (lb + k < log_idx.size())
                    check_eq({name, "_bypass_lat"}, log_cyc[lb+k], rise_q[rb+k]);
            end else begin
                if (eidx >= cap_a.size()) begin
                    check_eq({name, "_eng_loaded"}, cap_a.size(), eidx + 1);
                    exp_e = 0;
                    exp_g = ref_gcd(int'(a), int'(b));
                end else begin
                    lat    = lat_q[eidx];
                    exp_e  = (lat > TO) ? 1 : 0;
                    exp_g  = exp_e ? 0 : ref_gcd(int'(a), int'(b));
                    wait_c = (lat < TO) ? lat : TO;
                    check_eq({name, "_eng_a"}, cap_a[eidx], a);
                    check_eq({name, "_eng_b"}, cap_b[eidx], b);
                    if (lb + k < log_idx.size()) begin
                        check_eq({name, "_start_lat"}, start_q[eidx], rise_q[rb+k]);
                        check_eq({name, "_resp_lat"}, log_cyc[lb+k], start_q[eidx] + 3 + wait_c);
                    end
                end
                eidx++;
            end
            if (lb + k < log_idx.size()) begin
                check_eq({name, "_idx"}, log_idx[lb+k], pick);
                check_eq({name, "_gcd"}, log_gcd[lb+k], exp_g);
                check_eq({name, "_err"}, log_err[lb+k], exp_e);
                if (k > 0) check_eq({name, "_idle_gap"}, gap_q[rb+k], 1);
            end
        end
        check_eq({name, "_start_pulses"}, eng_start_cycles - sb, eidx - ebase);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_jobs();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        model_ptr = 0;
        @(posedge clk);
        #1;
    endtask

    function automatic int rand_opnd(input int f);
        if ($urandom_range(0, 7) == 0) return 0;
        return f * int'($urandom_range(1, 40));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        int ln, budget, ebase, nj, total, f;
        clear_jobs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs", {resp_valid, resp_gcd, resp_err, busy, eng_start, eng_data}, 64'd0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single request, requester drops req and scrambles operands after grant
        eng_fixed_lat = 13;
        clear_jobs();
        add_job(0, 143, 78);
        run_batch("single", 1, 1'b1);

        // all four requesting from reset
        do_reset();
        eng_fixed_lat = 6;
        add_job(0, 12, 18);
        add_job(0, 21, 14);
        add_job(1, 35, 49);
        add_job(2, 81, 27);
        add_job(3, 100, 75);
        run_batch("all4", 5, 1'b0);

        // zero operands resolved locally
        clear_jobs();
        add_job(2, 0, 45);
        add_job(2, 0, 0);
        add_job(2, 45, 0);
        run_batch("zero", 3, 1'b0);

        // watchdog on a hung engine, then normal service
        clear_jobs();
        eng_hang = 1'b1;
        add_job(1, 91, 35);
        run_batch("wdog", 1, 1'b0);
        eng_hang = 1'b0;
        eng_fixed_lat = 4;
        clear_jobs();
        add_job(3, 60, 48);
        run_batch("after_wdog", 1, 1'b0);

        // done on the last WAIT cycle beats the timeout; one cycle later does not
        eng_fixed_lat = TO;
        clear_jobs();
        add_job(0, 96, 36);
        run_batch("done_last", 1, 1'b0);
        eng_fixed_lat = TO + 1;
        clear_jobs();
        add_job(0, 50, 15);
        run_batch("done_late", 1, 1'b0);

        // reset in the middle of WAIT
        eng_fixed_lat = 5;
        clear_jobs();
        add_job(1, 0, 9);
        run_batch("pre_rst", 1, 1'b0);
        clear_jobs();
        eng_hang = 1'b1;
        add_job(2, 77, 33);
        ebase  = start_q.size();
        budget = 20;
        while (start_q.size() == ebase && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check_eq("rst_job_started", start_q.size(), ebase + 1);
        repeat (5) @(negedge clk);
        ln = log_idx.size();
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_async_outputs", {resp_valid, resp_gcd, resp_err, busy, eng_start, eng_data}, 64'd0);
        clear_jobs();
        model_ptr = 0;
        eng_hang  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_no_resp", log_idx.size(), ln);
        #1;
        clear_jobs();
        add_job(1, 44, 121);
        add_job(3, 64, 40);
        run_batch("post_rst", 2, 1'b0);

        // randomized batches
        eng_rand = 1'b1;
        for (int r = 0; r < 4; r++) begin
            clear_jobs();
            total = 0;
            for (int i = 0; i < N; i++) begin
                nj = int'($urandom_range(0, 3));
                for (int j = 0; j < nj; j++) begin
                    f = int'($urandom_range(1, 50));
                    add_job(i, rand_opnd(f), rand_opnd(f));
                    total++;
                end
            end
            if (total == 0) begin
                add_job(int'($urandom_range(0, N - 1)), 30, 42);
                total = 1;
            end
            run_batch("rand", total, 1'b0);
        end

        check_eq("onehot_resp", multi_hot, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
